// File: rtl/trng_collector_if.sv
// Word handshake between the TRNG collector and its consumer.
interface trng_collector_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  oValid;
    logic                  iReady;
    logic [DATA_WIDTH-1:0] oData;

    modport master (output oValid, output oData, input iReady);
    modport slave  (input oValid, input oData, output iReady);
endinterface

// File: rtl/trng_collector.sv
// Collects raw TRNG bits into words, with optional von Neumann debiasing,
// after a warmup period that lets the entropy oscillator settle.
module trng_collector #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SAMPLE_DIV    = 16,
    parameter int unsigned WARMUP_CYCLES = 256,
    parameter bit          DEBIAS        = 1'b1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iRandomBit,
    output logic             oEntropyEn,
    trng_collector_if.master bus
);
    localparam int unsigned SW = $clog2(SAMPLE_DIV);
    localparam int unsigned WW = $clog2(WARMUP_CYCLES + 1);
    localparam int unsigned BW = $clog2(DATA_WIDTH);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [WW-1:0] WARM_LAST   = WW'(WARMUP_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, COLLECT, OUTPUT} state_t;

    state_t                state;
    logic                  syncQ1, syncQ2;
    logic [WW-1:0]         warmCnt;
    logic [SW-1:0]         sampleCnt;
    logic [BW-1:0]         bitCnt;
    logic                  pairPhase;
    logic                  firstBit;
    logic [DATA_WIDTH-1:0] shiftReg;

    logic                  tick;
    logic                  acceptStrobe;
    logic                  acceptBit;
    logic [DATA_WIDTH-1:0] shiftNext;

    // In debias mode a bit is only produced on the second tick of a pair,
    // and only when the pair differs; the first bit of the pair is the result.
    always_comb begin
        tick         = (sampleCnt == SAMPLE_LAST);
        acceptStrobe = 1'b0;
        acceptBit    = 1'b0;
        if (DEBIAS) begin
            acceptStrobe = tick & pairPhase & (firstBit != syncQ2);
            acceptBit    = firstBit;
        end else begin
            acceptStrobe = tick;
            acceptBit    = syncQ2;
        end
        shiftNext = {shiftReg[DATA_WIDTH-2:0], acceptBit};
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            syncQ1     <= 1'b0;
            syncQ2     <= 1'b0;
            state      <= IDLE;
            warmCnt    <= '0;
            sampleCnt  <= '0;
            bitCnt     <= '0;
            pairPhase  <= 1'b0;
            firstBit   <= 1'b0;
            shiftReg   <= '0;
            oEntropyEn <= 1'b0;
            bus.oValid <= 1'b0;
            bus.oData  <= '0;
        end else begin
            syncQ1 <= iRandomBit;
            syncQ2 <= syncQ1;
            case (state)
                IDLE: begin
                    oEntropyEn <= 1'b0;
                    bus.oValid <= 1'b0;
                    if (iEn) begin
                        state      <= WARMUP;
                        warmCnt    <= '0;
                        oEntropyEn <= 1'b1;
                    end
                end
                WARMUP: begin
                    if (!iEn) begin
                        state      <= IDLE;
                        oEntropyEn <= 1'b0;
                    end else if (warmCnt == WARM_LAST) begin
                        state     <= COLLECT;
                        sampleCnt <= '0;
                        bitCnt    <= '0;
                        pairPhase <= 1'b0;
                    end else begin
                        warmCnt <= warmCnt + WW'(1);
                    end
                end
                COLLECT: begin
                    if (!iEn) begin
                        state      <= IDLE;
                        oEntropyEn <= 1'b0;
                    end else begin
                        sampleCnt <= tick ? '0 : sampleCnt + SW'(1);
                        if (tick) begin
                            pairPhase <= ~pairPhase;
                            if (!pairPhase) firstBit <= syncQ2;
                        end
                        if (acceptStrobe) begin
                            shiftReg <= shiftNext;
                            if (bitCnt == BIT_LAST) begin
                                bitCnt     <= '0;
                                bus.oData  <= shiftNext;
                                bus.oValid <= 1'b1;
                                state      <= OUTPUT;
                            end else begin
                                bitCnt <= bitCnt + BW'(1);
                            end
                        end
                    end
                end
                OUTPUT: begin
                    if (bus.oValid && bus.iReady) begin
                        bus.oValid <= 1'b0;
                        if (iEn) begin
                            state     <= COLLECT;
                            sampleCnt <= '0;
                            bitCnt    <= '0;
                            pairPhase <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            oEntropyEn <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trng_collector.sv
// Randomized bench for trng_collector: a raw-mode and a debias-mode instance
// checked against a positional word model built from the per-tick bit stream.
module tb_trng_collector;
    localparam int DW = 8;
    localparam int SD = 4;
    localparam int WU = 10;

    logic iClk = 1'b0;
    logic iRst;
    logic [1:0] en, rbit, ready;
    logic [1:0] vld, entEn;
    logic [1:0][DW-1:0] dat;
    int nAssert = 0;
    int nFail = 0;

    always #5 iClk = ~iClk;

    trng_collector_if #(.DATA_WIDTH(DW)) busRaw ();
    trng_collector_if #(.DATA_WIDTH(DW)) busDeb ();

    assign busRaw.iReady = ready[0];
    assign busDeb.iReady = ready[1];
    assign vld[0] = busRaw.oValid;
    assign vld[1] = busDeb.oValid;
    assign dat[0] = busRaw.oData;
    assign dat[1] = busDeb.oData;

    trng_collector #(.DATA_WIDTH(DW), .SAMPLE_DIV(SD), .WARMUP_CYCLES(WU), .DEBIAS(1'b0)) dutRaw (
        .iClk(iClk), .iRst(iRst), .iEn(en[0]), .iRandomBit(rbit[0]),
        .oEntropyEn(entEn[0]), .bus(busRaw.master));

    trng_collector #(.DATA_WIDTH(DW), .SAMPLE_DIV(SD), .WARMUP_CYCLES(WU), .DEBIAS(1'b1)) dutDeb (
        .iClk(iClk), .iRst(iRst), .iEn(en[1]), .iRandomBit(rbit[1]),
        .oEntropyEn(entEn[1]), .bus(busDeb.master));

    // Returns ticks needed for one word (or -1), and the word itself.
    function automatic int model(input bit debias, input bit bits[$], output logic [DW-1:0] word);
        int acc = 0;
        word = '0;
        if (!debias) begin
            for (int i = 0; i < bits.size(); i++) begin
                word[DW-1-acc] = bits[i];
                acc++;
                if (acc == DW) return i + 1;
            end
        end else begin
            for (int j = 0; j + 1 < bits.size(); j += 2) begin
                if (bits[j] != bits[j+1]) begin
                    word[DW-1-acc] = bits[j];
                    acc++;
                    if (acc == DW) return j + 2;
                end
            end
        end
        return -1;
    endfunction

    task automatic random_bits(output bit q[$]);
        q = {};
        for (int i = 0; i < 80; i++) q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic start_word(input int d);
        en[d] = 1'b1;
        @(posedge iClk); #1;
        nAssert++;
        if (entEn[d] !== 1'b1) begin
            nFail++;
            $display("FAIL start_entropy_en dut%0d: got %b want 1", d, entEn[d]);
        end
        repeat (WU) @(posedge iClk);
        #1;
    endtask

    // Called #1 after the edge that enters COLLECT.
    task automatic collect_word(input int d, input bit bits[$], input string name);
        logic [DW-1:0] exp;
        int ticks;
        bit early = 1'b0;
        ticks = model(d == 1, bits, exp);
        for (int k = 0; k < ticks; k++) begin
            rbit[d] = bits[k];
            repeat (SD) @(posedge iClk);
            #1;
            if (k < ticks - 1 && vld[d] !== 1'b0) early = 1'b1;
        end
        nAssert++;
        if (early) begin
            nFail++;
            $display("FAIL %s_early_valid dut%0d: got valid before tick %0d want none", name, d, ticks);
        end
        nAssert++;
        if (vld[d] !== 1'b1) begin
            nFail++;
            $display("FAIL %s_valid dut%0d: got %b want 1", name, d, vld[d]);
        end
        nAssert++;
        if (dat[d] !== exp) begin
            nFail++;
            $display("FAIL %s_data dut%0d: got %h want %h", name, d, dat[d], exp);
        end
    endtask

    task automatic handshake(input int d, input int stall, input bit keepEn, input string name);
        logic [DW-1:0] hold;
        bit bad = 1'b0;
        hold = dat[d];
        repeat (stall) begin
            @(posedge iClk); #1;
            if (vld[d] !== 1'b1 || dat[d] !== hold) bad = 1'b1;
        end
        nAssert++;
        if (bad) begin
            nFail++;
            $display("FAIL %s_stall_hold dut%0d: got valid=%b data=%h want 1/%h", name, d, vld[d], dat[d], hold);
        end
        en[d] = keepEn;
        ready[d] = 1'b1;
        @(posedge iClk); #1;
        ready[d] = 1'b0;
        nAssert++;
        if (vld[d] !== 1'b0 || entEn[d] !== keepEn) begin
            nFail++;
            $display("FAIL %s_transfer dut%0d: got valid=%b entEn=%b want 0/%b", name, d, vld[d], entEn[d], keepEn);
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        en = '0; rbit = '0; ready = '0;
        @(posedge iClk); #1;
        for (int d = 0; d < 2; d++) begin
            nAssert++;
            if (vld[d] !== 1'b0 || dat[d] !== 8'h00 || entEn[d] !== 1'b0) begin
                nFail++;
                $display("FAIL reset_state dut%0d: got valid=%b data=%h entEn=%b want 0/00/0", d, vld[d], dat[d], entEn[d]);
            end
        end
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
    endtask

    task automatic test_raw_latency();
        rbit[0] = 1'b1;
        en[0] = 1'b1;
        @(posedge iClk); #1;
        nAssert++;
        if (entEn[0] !== 1'b1) begin
            nFail++;
            $display("FAIL latency_entropy_en: got %b want 1", entEn[0]);
        end
        for (int e = 1; e <= WU + DW * SD; e++) begin
            @(posedge iClk); #1;
            if (e == WU + DW * SD - 1) begin
                nAssert++;
                if (vld[0] !== 1'b0) begin
                    nFail++;
                    $display("FAIL latency_not_early: got valid=%b at edge %0d want 0", vld[0], e);
                end
            end
        end
        nAssert++;
        if (vld[0] !== 1'b1 || dat[0] !== 8'hFF) begin
            nFail++;
            $display("FAIL latency_word: got valid=%b data=%h want 1/ff", vld[0], dat[0]);
        end
        handshake(0, 0, 1'b1, "latency");
    endtask

    task automatic test_random_words(input int d, input int n);
        bit q[$];
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            do random_bits(q); while (model(d == 1, q, w) < 0);
            collect_word(d, q, "random");
            handshake(d, $urandom_range(0, 4), (i != n - 1), "random");
        end
    endtask

    task automatic test_debias_pattern();
        bit q[$];
        bit pat[8] = '{0, 1, 1, 0, 1, 1, 0, 0};
        q = {};
        for (int r = 0; r < 5; r++)
            for (int i = 0; i < 8; i++) q.push_back(pat[i]);
        start_word(1);
        collect_word(1, q, "pattern");
        nAssert++;
        if (dat[1] !== 8'h55) begin
            nFail++;
            $display("FAIL pattern_55: got %h want 55", dat[1]);
        end
        handshake(1, 20, 1'b0, "stall20");
    endtask

    task automatic test_abort();
        bit q[$];
        start_word(0);
        for (int k = 0; k < 5; k++) begin
            rbit[0] = 1'b1;
            repeat (SD) @(posedge iClk);
            #1;
        end
        en[0] = 1'b0;
        @(posedge iClk); #1;
        nAssert++;
        if (entEn[0] !== 1'b0 || vld[0] !== 1'b0) begin
            nFail++;
            $display("FAIL abort_idle: got entEn=%b valid=%b want 0/0", entEn[0], vld[0]);
        end
        repeat (3) @(posedge iClk);
        #1;
        random_bits(q);
        start_word(0);
        collect_word(0, q, "after_abort");
        handshake(0, 1, 1'b0, "after_abort");
    endtask

    task automatic test_warmup_abort();
        bit q[$];
        en[0] = 1'b1;
        repeat (4) @(posedge iClk);
        #1;
        en[0] = 1'b0;
        @(posedge iClk); #1;
        nAssert++;
        if (entEn[0] !== 1'b0) begin
            nFail++;
            $display("FAIL warmup_abort: got entEn=%b want 0", entEn[0]);
        end
        random_bits(q);
        start_word(0);
        collect_word(0, q, "after_warmup_abort");
        handshake(0, 0, 1'b0, "after_warmup_abort");
    endtask

    task automatic test_reset_in_output();
        bit q[$];
        bit seen = 1'b0;
        random_bits(q);
        start_word(0);
        collect_word(0, q, "pre_reset");
        ready[0] = 1'b0;
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        en[0] = 1'b0;
        nAssert++;
        if (vld[0] !== 1'b0 || dat[0] !== 8'h00 || entEn[0] !== 1'b0) begin
            nFail++;
            $display("FAIL reset_output: got valid=%b data=%h entEn=%b want 0/00/0", vld[0], dat[0], entEn[0]);
        end
        ready[0] = 1'b1;
        repeat (6) begin
            @(posedge iClk); #1;
            if (vld[0] !== 1'b0) seen = 1'b1;
        end
        ready[0] = 1'b0;
        nAssert++;
        if (seen) begin
            nFail++;
            $display("FAIL reset_dropped_word: got valid=1 after reset want 0");
        end
    endtask

    initial begin
        test_reset();
        test_raw_latency();
        test_random_words(0, 4);
        start_word(1);
        test_random_words(1, 4);
        test_debias_pattern();
        test_abort();
        test_warmup_abort();
        test_reset_in_output();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
